// File: rtl/gpu_pkg.sv
// Shared core/fetcher handshake codes for the GPU core slice.
package gpu_pkg;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding prefetched instructions; flush beats push in the same cycle.
module prefetch_fifo #(
  parameter int DEPTH     = 4,
  parameter int DATA_BITS = 16,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [DATA_BITS-1:0] head_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher that streams sequential addresses into a small prefetch
// buffer between FETCH phases; a non-sequential PC flushes and redirects.
module prefetch_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int DEPTH                 = 4,
  parameter int PERF_BITS             = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             prefetch_enable,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [PERF_BITS-1:0]             hit_count,
  output logic [PERF_BITS-1:0]             miss_count
);

  localparam int AW    = PROGRAM_MEM_ADDR_BITS;
  localparam int DW    = PROGRAM_MEM_DATA_BITS;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetcher_state_t state_q, state_d;
  logic [AW-1:0]  head_pc_q, head_pc_d;
  logic [AW-1:0]  fetch_addr_q, fetch_addr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           valid_q, valid_d;
  logic           discard_q, discard_d;
  logic [DW-1:0]  instr_q, instr_d;
  logic [PERF_BITS-1:0] hit_q, hit_d, miss_q, miss_d;

  logic [DW-1:0]    fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic resp, fetch_req, hit, miss, bypass, push, issue;

  assign resp      = valid_q && mem_read_ready;
  assign fetch_req = (state_q == IDLE) && (core_state == CORE_FETCH);
  assign hit       = fetch_req && (fifo_count != '0) && (head_pc_q == current_pc);
  assign miss      = fetch_req && !hit;
  // A response landing on the redirect edge belongs to the old stream and is dropped.
  assign bypass    = resp && !discard_q && (state_q == FETCHING) && (addr_q == head_pc_q);
  assign push      = resp && !discard_q && !miss && !bypass;
  // Only one request is ever outstanding and issue needs valid_q low, so count alone is the credit.
  assign issue     = !valid_q && !miss && (fifo_count < DEPTH_CNT)
                     && (prefetch_enable || (state_q == FETCHING));

  prefetch_fifo #(
    .DEPTH     (DEPTH),
    .DATA_BITS (DW),
    .CNT_W     (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (mem_read_data),
    .pop_i   (hit),
    .flush_i (miss),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // NOTE: every combinational output takes its hold value first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    fetch_addr_d = fetch_addr_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    discard_d    = discard_q;
    instr_d      = instr_q;
    hit_d        = hit_q;
    miss_d       = miss_q;

    if (resp) begin
      valid_d = 1'b0;
      if (discard_q)  discard_d    = 1'b0;
      else if (!miss) fetch_addr_d = fetch_addr_q + 1'b1;
    end
    if (issue) begin
      valid_d = 1'b1;
      addr_d  = fetch_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (hit) begin
          instr_d   = fifo_head;
          head_pc_d = head_pc_q + 1'b1;
          hit_d     = hit_q + 1'b1;
          state_d   = FETCHED;
        end else if (miss) begin
          head_pc_d    = current_pc;
          fetch_addr_d = current_pc;
          miss_d       = miss_q + 1'b1;
          discard_d    = valid_q && !mem_read_ready;
          state_d      = FETCHING;
        end
      end
      FETCHING: begin
        if (bypass) begin
          instr_d   = mem_read_data;
          head_pc_d = head_pc_q + 1'b1;
          state_d   = FETCHED;
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      head_pc_q    <= '0;
      fetch_addr_q <= '0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      discard_q    <= 1'b0;
      instr_q      <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      head_pc_q    <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      discard_q    <= discard_d;
      instr_q      <= instr_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Scoreboard bench for prefetch_fetcher with a variable-latency program memory model.
module tb_prefetch_fetcher;
  import gpu_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    core_state;
  logic [AW-1:0] current_pc;
  logic          prefetch_enable;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;
  logic [PW-1:0] hit_count, miss_count;

  prefetch_fetcher #(
    .PROGRAM_MEM_ADDR_BITS (AW),
    .PROGRAM_MEM_DATA_BITS (DW),
    .DEPTH                 (4),
    .PERF_BITS             (PW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .prefetch_enable  (prefetch_enable),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // Program memory: ready on the lat-th cycle a request is seen; logs each new request.
  int            lat = 3;
  int            wait_cnt = 0;
  bit            prev_valid = 1'b0;
  bit            watch_stray = 1'b0;
  int            stray = 0;
  logic [AW-1:0] req_log[$];

  initial begin
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_read_valid) begin
        if (!prev_valid) begin
          req_log.push_back(mem_read_address);
          if (watch_stray && fetcher_state != FETCHING) stray++;
        end
        wait_cnt++;
        mem_read_ready = (wait_cnt >= lat);
        mem_read_data  = mem_fn(mem_read_address);
      end else begin
        wait_cnt       = 0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
      end
      prev_valid = mem_read_valid;
    end
  end

  logic [DW-1:0] sb_q[$];

  task automatic do_fetch(input logic [AW-1:0] pc, input bit exp_hit);
    int cyc = 0;
    sb_q.push_back(mem_fn(pc));
    @(negedge clk);
    core_state = CORE_FETCH;
    current_pc = pc;
    do begin
      @(negedge clk);
      cyc++;
    end while (fetcher_state != FETCHED && cyc < 400);
    check($sformatf("fetched_%0h", pc), fetcher_state, FETCHED);
    check($sformatf("hit1cyc_%0h", pc), 32'(cyc == 1), 32'(exp_hit));
    check($sformatf("instr_%0h", pc), instruction, sb_q.pop_front());
    core_state = CORE_DECODE;
    @(negedge clk);
    core_state = 3'b000;
    check($sformatf("idle_%0h", pc), fetcher_state, IDLE);
  endtask

  task automatic wait_valid(input bit level);
    int n = 0;
    while (mem_read_valid != level && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", mem_read_valid, level);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish after 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] exp_addr[4];
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    reset = 1'b1;
    core_state = 3'b000;
    current_pc = '0;
    prefetch_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", fetcher_state, IDLE);
    check("rst_valid", mem_read_valid, 0);
    check("rst_addr", mem_read_address, 0);
    check("rst_instr", instruction, 0);
    check("rst_hits", hit_count, 0);
    check("rst_miss", miss_count, 0);

    // Cold miss with a 3-cycle memory.
    lat = 3;
    do_fetch(8'h10, 1'b0);
    check("t1_miss", miss_count, 1);

    // Sequential run served from the prefetch buffer.
    prefetch_enable = 1'b1;
    lat = 1;
    repeat (16) @(negedge clk);
    do_fetch(8'h11, 1'b1);
    do_fetch(8'h12, 1'b1);
    do_fetch(8'h13, 1'b1);
    check("t2_hits", hit_count, 3);
    check("t2_miss", miss_count, 1);

    // Branch while a slow prefetch is in flight: its response must be discarded.
    lat = 6;
    do_fetch(8'h14, 1'b1);
    wait_valid(1'b1);
    do_fetch(8'h40, 1'b0);
    check("t3_hits", hit_count, 4);
    check("t3_miss", miss_count, 2);

    // Address wrap at the top of program memory.
    lat = 1;
    repeat (20) @(negedge clk);
    req_log.delete();
    do_fetch(8'hFE, 1'b0);
    repeat (16) @(negedge clk);
    do_fetch(8'hFF, 1'b1);
    do_fetch(8'h00, 1'b1);
    check("t4_log_len", 32'(req_log.size() >= 4), 1);
    if (req_log.size() >= 4)
      for (int i = 0; i < 4; i++) check($sformatf("t4_req%0d", i), req_log[i], exp_addr[i]);
    check("t4_hits", hit_count, 6);
    check("t4_miss", miss_count, 3);

    // Prefetch disabled: only demand requests, every FETCH misses.
    prefetch_enable = 1'b0;
    wait_valid(1'b0);
    watch_stray = 1'b1;
    do_fetch(8'h20, 1'b0);
    do_fetch(8'h21, 1'b0);
    repeat (10) @(negedge clk);
    watch_stray = 1'b0;
    check("t5_stray", stray, 0);
    check("t5_miss", miss_count, 5);
    check("t5_hits", hit_count, 6);

    // Reset in the middle of an outstanding request.
    prefetch_enable = 1'b1;
    lat = 8;
    wait_valid(1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_valid", mem_read_valid, 0);
    check("t6_state", fetcher_state, IDLE);
    check("t6_hits", hit_count, 0);
    check("t6_miss", miss_count, 0);
    check("t6_instr", instruction, 0);
    reset = 1'b0;

    lat = 2;
    do_fetch(8'h30, 1'b0);
    check("t6_miss_after", miss_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
